vdp_super_res_writer: RTL

- CPU-side pixel writer for the 64x64 super high-res framebuffer in SDRAM.
- Accepts R, G, B bytes from the CPU I/O port decoder and packs them into 24-bit pixels.
- Issues 32-bit VRAM write requests at a 17-bit auto-incrementing address, using the same pixel format and address stride as the display fetch path.
- Sits between the CPU port decoder and the VRAM arbiter.

---
 rtl/vdp_super_res_pkg.sv | 23 ++
 rtl/vdp_super_res_wr_queue.sv | 73 +++++++
 rtl/vdp_super_res_writer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vdp_super_res_pkg.sv
// rtl/vdp_super_res_pkg.sv - shared types and constants for the 64x64 super high-res framebuffer
package vdp_super_res_pkg;

  typedef logic [23:0] rgb_t;
  typedef logic [16:0] vram_addr_t;

  localparam int SUPER_RES_WIDTH  = 64;
  localparam int SUPER_RES_HEIGHT = 64;

  localparam logic [1:0] PORT_DATA    = 2'd0;
  localparam logic [1:0] PORT_ADDR_LO = 2'd1;
  localparam logic [1:0] PORT_ADDR_HI = 2'd2;
  localparam logic [1:0] PORT_CTRL    = 2'd3;

  localparam int CTRL_FILL_BIT = 7;

  typedef enum logic [1:0] {
    FILL_IDLE       = 2'd0,
    FILL_WAIT_EMPTY = 2'd1,
    FILL_RUN        = 2'd2
  } fill_state_t;

endpackage

// File: rtl/vdp_super_res_wr_queue.sv
// rtl/vdp_super_res_wr_queue.sv - pending/staging pixel buffer with VRAM req/ack handshake
module vdp_super_res_wr_queue
  import vdp_super_res_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [16:0] push_addr,
  input  logic [23:0] push_data,
  input  logic        ack,
  output logic        req,
  output logic [16:0] addr,
  output logic [23:0] data,
  output logic        pend_full,
  output logic        stage_full
);

  logic       p_valid;
  logic       s_valid;
  vram_addr_t p_addr;
  vram_addr_t s_addr;
  rgb_t       p_data;
  rgb_t       s_data;
  logic       hs;
  logic       pend_free;

  assign hs = req & ack;
  // Pending counts as free when it is empty or is being retired with nothing staged behind it.
  assign pend_free = ~p_valid | (hs & ~s_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_valid <= 1'b0;
      s_valid <= 1'b0;
      p_addr  <= '0;
      s_addr  <= '0;
      p_data  <= '0;
      s_data  <= '0;
      req     <= 1'b0;
    end else begin
      if (hs) begin
        if (s_valid) begin
          p_addr  <= s_addr;
          p_data  <= s_data;
          s_valid <= 1'b0;
        end else begin
          p_valid <= 1'b0;
          req     <= 1'b0;
        end
      end else if (p_valid) begin
        req <= 1'b1;
      end

      if (push) begin
        if (pend_free) begin
          p_valid <= 1'b1;
          p_addr  <= push_addr;
          p_data  <= push_data;
        end else begin
          s_valid <= 1'b1;
          s_addr  <= push_addr;
          s_data  <= push_data;
        end
      end
    end
  end

  assign addr       = p_addr;
  assign data       = p_data;
  assign pend_full  = p_valid;
  assign stage_full = s_valid;

endmodule

// File: rtl/vdp_super_res_writer.sv
// rtl/vdp_super_res_writer.sv - CPU RGB byte packer and VRAM pixel writer; fill option via VDP_SUPER_RES_FILL_EN
module vdp_super_res_writer
  import vdp_super_res_pkg::*;
#(
  parameter int ADDR_STEP  = 2,
  parameter int FILL_COUNT = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        super_high_res,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_port,
  input  logic [7:0]  cpu_data,
  output logic        busy,
  output logic        overflow,
  output logic        vram_wr_req,
  input  logic        vram_wr_ack,
  output logic [16:0] vram_wr_addr,
  output logic [31:0] vram_wr_data
);

  localparam vram_addr_t STEP = 17'(ADDR_STEP);

  logic [1:0] byte_idx;
  logic [7:0] r_byte;
  logic [7:0] g_byte;
  vram_addr_t addr_ptr;
  logic       overflow_q;
  logic       data_wr;
  logic       busy_base;
  logic       pix_push;
  logic       drop;
  logic       filling;
  logic       fill_push;
  logic       push;
  rgb_t       push_data;
  rgb_t       q_data;
  logic       pend_full;
  logic       stage_full;

  assign data_wr   = cpu_wr & (cpu_port == PORT_DATA) & super_high_res;
  assign busy_base = stage_full & (byte_idx == 2'd2);
  assign pix_push  = data_wr & ~filling & (byte_idx == 2'd2) & ~busy_base;
  assign drop      = data_wr & (filling | busy_base);

`ifdef VDP_SUPER_RES_FILL_EN
  localparam int CNT_W = $clog2(FILL_COUNT + 1);

  fill_state_t      state;
  fill_state_t      state_next;
  logic [CNT_W-1:0] fill_left;
  rgb_t             last_colour;
  logic             fill_start;
  logic             queue_empty;

  assign fill_start  = cpu_wr & (cpu_port == PORT_CTRL) & cpu_data[CTRL_FILL_BIT] & (state == FILL_IDLE);
  assign queue_empty = ~pend_full & ~stage_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL_IDLE:       if (fill_start) state_next = FILL_WAIT_EMPTY;
      FILL_WAIT_EMPTY: if (queue_empty) state_next = FILL_RUN;
      FILL_RUN:        if ((fill_left == '0) && queue_empty) state_next = FILL_IDLE;
      default:         state_next = FILL_IDLE;
    endcase
  end

  always_comb begin
    filling   = 1'b0;
    fill_push = 1'b0;
    case (state)
      FILL_WAIT_EMPTY: filling = 1'b1;
      FILL_RUN: begin
        filling   = 1'b1;
        fill_push = (fill_left != '0) & ~stage_full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_left   <= '0;
      last_colour <= '0;
    end else begin
      if (fill_start)     fill_left <= CNT_W'(FILL_COUNT);
      else if (fill_push) fill_left <= fill_left - 1'b1;
      if (pix_push) last_colour <= {r_byte, g_byte, cpu_data};
    end
  end

  assign push_data = fill_push ? last_colour : {r_byte, g_byte, cpu_data};
`else
  logic unused_fill;

  assign filling     = 1'b0;
  assign fill_push   = 1'b0;
  assign push_data   = {r_byte, g_byte, cpu_data};
  assign unused_fill = pend_full ^ (FILL_COUNT == 0);
`endif

  assign push = pix_push | fill_push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx   <= 2'd0;
      r_byte     <= 8'h00;
      g_byte     <= 8'h00;
      addr_ptr   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) addr_ptr <= addr_ptr + STEP;
      if (drop) overflow_q <= 1'b1;

      if (!super_high_res) begin
        byte_idx <= 2'd0;
      end else if (data_wr && !filling) begin
        case (byte_idx)
          2'd0: begin r_byte <= cpu_data; byte_idx <= 2'd1; end
          2'd1: begin g_byte <= cpu_data; byte_idx <= 2'd2; end
          2'd2: if (!busy_base) byte_idx <= 2'd0;
          default: byte_idx <= 2'd0;
        endcase
      end

      // Address writes restart pixel assembly; the fill owns addr_ptr while it runs.
      if (cpu_wr && !filling) begin
        case (cpu_port)
          PORT_ADDR_LO: begin addr_ptr[7:0]  <= cpu_data; byte_idx <= 2'd0; end
          PORT_ADDR_HI: begin addr_ptr[15:8] <= cpu_data; byte_idx <= 2'd0; end
          PORT_CTRL: begin
            addr_ptr[16] <= cpu_data[0];
            byte_idx     <= 2'd0;
            overflow_q   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  vdp_super_res_wr_queue u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_addr  (addr_ptr),
    .push_data  (push_data),
    .ack        (vram_wr_ack),
    .req        (vram_wr_req),
    .addr       (vram_wr_addr),
    .data       (q_data),
    .pend_full  (pend_full),
    .stage_full (stage_full)
  );

  assign vram_wr_data = {8'h00, q_data};
  assign busy         = busy_base | filling;
  assign overflow     = overflow_q;

endmodule
